// File: rtl/spi_frame_scheduler.sv
// spi_frame_scheduler: streams one frame of 8-bit pixels from the frame BRAM
// into the 4-line SPI sender, one pixel per SPI transaction.
// Optional build macro: SPI_SCHED_WATCHDOG_EN adds a wait-state watchdog and
// the sticky timeout_out port.
module spi_frame_scheduler #(
  parameter int H_PIXELS     = 320,
  parameter int V_PIXELS     = 180,
  parameter int ADDR_W       = 16,
  parameter int BRAM_LATENCY = 2,
  parameter int GAP_CYCLES   = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              frame_start_in,
  output logic [ADDR_W-1:0] bram_addr_out,
  input  logic [7:0]        bram_data_in,
  input  logic              spi_cs_in,
  output logic              spi_trigger_out,
  output logic [7:0]        spi_data_out,
  output logic [9:0]        spi_hcount_out,
  output logic [8:0]        spi_vcount_out,
  output logic              busy_out,
  output logic              frame_done_out
`ifdef SPI_SCHED_WATCHDOG_EN
  ,
  output logic              timeout_out
`endif
);

  localparam logic [9:0] H_LAST   = 10'(H_PIXELS - 1);
  localparam logic [8:0] V_LAST   = 9'(V_PIXELS - 1);
  localparam logic [7:0] LAT_CNT  = 8'(BRAM_LATENCY);
  localparam logic [7:0] GAP_CNT  = 8'(GAP_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_TRIG,
    ST_WAIT_LOW,
    ST_WAIT_HIGH,
    ST_GAP,
    ST_ADVANCE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [9:0]          h_q, h_d;
  logic [8:0]          v_q, v_d;
  logic [7:0]          wait_q, wait_d;
  logic [7:0]          data_q, data_d;
  logic [9:0]          hout_q, hout_d;
  logic [8:0]          vout_q, vout_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
`ifdef SPI_SCHED_WATCHDOG_EN
  logic [15:0]         wd_q, wd_d;
  logic                timeout_q, timeout_d;
`endif

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      h_q       <= '0;
      v_q       <= '0;
      wait_q    <= '0;
      data_q    <= '0;
      hout_q    <= '0;
      vout_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SPI_SCHED_WATCHDOG_EN
      wd_q      <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      h_q       <= h_d;
      v_q       <= v_d;
      wait_q    <= wait_d;
      data_q    <= data_d;
      hout_q    <= hout_d;
      vout_q    <= vout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef SPI_SCHED_WATCHDOG_EN
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  // Next-state logic: fetch, trigger, wait for the CS low/high handshake, gap, advance.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    h_d     = h_q;
    v_d     = v_q;
    wait_d  = wait_q;
    data_d  = data_q;
    hout_d  = hout_q;
    vout_d  = vout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef SPI_SCHED_WATCHDOG_EN
    wd_d      = wd_q;
    timeout_d = timeout_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // A start coinciding with the done pulse belongs to the old frame and is dropped.
        if (frame_start_in && !done_q) begin
          state_d = ST_FETCH;
          busy_d  = 1'b1;
          addr_d  = '0;
          h_d     = '0;
          v_d     = '0;
          wait_d  = '0;
        end
      end
      ST_FETCH: begin
        // Address has been on the bus since entry; data is valid once the latency has elapsed.
        if (wait_q == LAT_CNT) begin
          data_d  = bram_data_in;
          hout_d  = h_q;
          vout_d  = v_q;
          state_d = ST_TRIG;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      ST_TRIG: begin
        state_d = ST_WAIT_LOW;
      end
      ST_WAIT_LOW: begin
        if (!spi_cs_in) begin
          state_d = ST_WAIT_HIGH;
        end
      end
      ST_WAIT_HIGH: begin
        if (spi_cs_in) begin
          state_d = ST_GAP;
          wait_d  = GAP_CNT;
        end
      end
      ST_GAP: begin
        if (wait_q == 8'd0) begin
          state_d = ST_ADVANCE;
        end else begin
          wait_d = wait_q - 8'd1;
        end
      end
      ST_ADVANCE: begin
        if ((h_q == H_LAST) && (v_q == V_LAST)) begin
          // Last pixel: address stays on the final location, no wrap.
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          if (h_q == H_LAST) begin
            h_d = '0;
            v_d = v_q + 9'd1;
          end else begin
            h_d = h_q + 10'd1;
          end
          addr_d  = addr_q + 1'b1;
          wait_d  = '0;
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef SPI_SCHED_WATCHDOG_EN
    // Counter runs only while dwelling in a wait state; any state change clears it.
    // Firing when the old value is 65534 means the counter has just reached 65535.
    if (((state_q == ST_WAIT_LOW) || (state_q == ST_WAIT_HIGH)) && (state_d == state_q)) begin
      if (wd_q == 16'hFFFE) begin
        timeout_d = 1'b1;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
        wd_d      = '0;
      end else begin
        wd_d = wd_q + 16'd1;
      end
    end else begin
      wd_d = '0;
    end
`endif
  end

  assign bram_addr_out   = addr_q;
  assign spi_trigger_out = (state_q == ST_TRIG);
  assign spi_data_out    = data_q;
  assign spi_hcount_out  = hout_q;
  assign spi_vcount_out  = vout_q;
  assign busy_out        = busy_q;
  assign frame_done_out  = done_q;
`ifdef SPI_SCHED_WATCHDOG_EN
  assign timeout_out     = timeout_q;
`endif

endmodule
